// File: rtl/cache_pkg.sv
// Shared definitions for the cache refill arbiter.
// Holds the beat/offset geometry of a two-word block, the requester indices
// used by the round-robin picker, and the transaction state encoding.
package cache_pkg;

    // One beat-index bit selects word 0/1; two bits address a byte within a word.
    localparam int unsigned BEAT_W     = 1;
    localparam int unsigned WORD_OFF_W = 2;
    localparam int unsigned BLK_OFF_W  = BEAT_W + WORD_OFF_W;

    // Bit positions of the two requesters in the arbiter request vector.
    localparam int unsigned REQ_IDX_I = 0;
    localparam int unsigned REQ_IDX_D = 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WB0  = 3'd1,
        ST_WB1  = 3'd2,
        ST_RD0  = 3'd3,
        ST_RD1  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick between the I-cache and D-cache requesters.
// Ports:
//   req_i      - request vector, bit REQ_IDX_I = I-cache, bit REQ_IDX_D = D-cache
//   last_d_i   - 1 when the previous grant went to the D-cache
//   valid_c_o  - at least one request is pending (combinational)
//   pick_d_c_o - 1 selects the D-cache, 0 the I-cache (combinational)
module rr_arbiter2
    import cache_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_d_i,
    output logic       valid_c_o,
    output logic       pick_d_c_o
);

    // A lone request wins outright; on a tie the side not served last wins.
    always_comb begin
        valid_c_o  = req_i[REQ_IDX_I] | req_i[REQ_IDX_D];
        pick_d_c_o = req_i[REQ_IDX_D];
        if (req_i[REQ_IDX_I] && req_i[REQ_IDX_D]) begin
            pick_d_c_o = ~last_d_i;
        end
    end

endmodule

// File: rtl/cache_refill_arbiter.sv
// Shares one single-word memory port between I-cache refills and D-cache
// misses (with optional dirty-victim writeback) for two-word cache blocks.
// Ports:
//   Clk, Reset                - clock, asynchronous active-high reset
//   i_req/i_addr/i_done       - I-cache refill request, miss address, completion pulse
//   d_req/d_wb/d_wb_addr/
//   d_wb_data/d_addr/d_done   - D-cache miss request, victim info, miss address, completion pulse
//   rf_data                   - refilled block returned to whichever cache owned the transaction
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_ready/
//   mem_rdata                 - single-word memory command/response
//   busy                      - a transaction is in progress
module cache_refill_arbiter
    import cache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned Block_Size = 2
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           i_req,
    input  logic [ADDR_WIDTH-1:0]          i_addr,
    output logic                           i_done,
    input  logic                           d_req,
    input  logic                           d_wb,
    input  logic [ADDR_WIDTH-1:0]          d_wb_addr,
    input  logic [DATA_WIDTH*Block_Size-1:0] d_wb_data,
    input  logic [ADDR_WIDTH-1:0]          d_addr,
    output logic                           d_done,
    output logic [DATA_WIDTH*Block_Size-1:0] rf_data,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [DATA_WIDTH-1:0]          mem_wdata,
    input  logic                           mem_ready,
    input  logic [DATA_WIDTH-1:0]          mem_rdata,
    output logic                           busy
);

    localparam int unsigned BLK_W = ADDR_WIDTH - BLK_OFF_W;
    localparam int unsigned BLK_DW = DATA_WIDTH * Block_Size;

    state_t                state_q;
    logic                  owner_d_q;
    logic                  last_d_q;
    logic [BLK_W-1:0]      wb_blk_q;
    logic [BLK_W-1:0]      rd_blk_q;
    logic [DATA_WIDTH-1:0] wb_w1_q;

    logic                  gnt_valid_c;
    logic                  gnt_d_c;
    logic [BLK_W-1:0]      miss_blk_c;
    logic                  unused_low_bits_c;

    // Byte address of one word of a block: block number, beat index, zero byte offset.
    function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [BLK_W-1:0] blk,
                                                        input logic [BEAT_W-1:0] beat);
        return {blk, beat, WORD_OFF_W'(0)};
    endfunction

    rr_arbiter2 u_rr (
        .req_i      ({d_req, i_req}),
        .last_d_i   (last_d_q),
        .valid_c_o  (gnt_valid_c),
        .pick_d_c_o (gnt_d_c)
    );

    // Block number of the miss that would be granted this cycle.
    assign miss_blk_c = gnt_d_c ? d_addr[ADDR_WIDTH-1:BLK_OFF_W]
                                : i_addr[ADDR_WIDTH-1:BLK_OFF_W];

    // Byte offsets inside a block are discarded; block alignment is implied.
    assign unused_low_bits_c = ^{i_addr[BLK_OFF_W-1:0], d_addr[BLK_OFF_W-1:0],
                                 d_wb_addr[BLK_OFF_W-1:0]};

    // Transaction sequencer; every output is loaded together with the state it belongs to.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            owner_d_q <= 1'b0;
            last_d_q  <= 1'b0;      // "I served last", so D wins the first tie
            wb_blk_q  <= '0;
            rd_blk_q  <= '0;
            wb_w1_q   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rf_data   <= '0;
            busy      <= 1'b0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_valid_c) begin
                        owner_d_q <= gnt_d_c;
                        last_d_q  <= gnt_d_c;
                        busy      <= 1'b1;
                        mem_req   <= 1'b1;
                        rd_blk_q  <= miss_blk_c;
                        wb_blk_q  <= d_wb_addr[ADDR_WIDTH-1:BLK_OFF_W];
                        wb_w1_q   <= d_wb_data[BLK_DW-1:DATA_WIDTH];
                        if (gnt_d_c && d_wb) begin
                            state_q   <= ST_WB0;
                            mem_we    <= 1'b1;
                            mem_addr  <= beat_addr(d_wb_addr[ADDR_WIDTH-1:BLK_OFF_W], BEAT_W'(0));
                            mem_wdata <= d_wb_data[DATA_WIDTH-1:0];
                        end else begin
                            state_q   <= ST_RD0;
                            mem_we    <= 1'b0;
                            mem_addr  <= beat_addr(miss_blk_c, BEAT_W'(0));
                        end
                    end
                end
                ST_WB0: begin
                    if (mem_ready) begin
                        state_q   <= ST_WB1;
                        mem_addr  <= beat_addr(wb_blk_q, BEAT_W'(1));
                        mem_wdata <= wb_w1_q;
                    end
                end
                ST_WB1: begin
                    if (mem_ready) begin
                        state_q   <= ST_RD0;
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                        mem_addr  <= beat_addr(rd_blk_q, BEAT_W'(0));
                    end
                end
                ST_RD0: begin
                    if (mem_ready) begin
                        state_q                  <= ST_RD1;
                        rf_data[DATA_WIDTH-1:0]  <= mem_rdata;
                        mem_addr                 <= beat_addr(rd_blk_q, BEAT_W'(1));
                    end
                end
                ST_RD1: begin
                    if (mem_ready) begin
                        state_q                          <= ST_DONE;
                        rf_data[BLK_DW-1:DATA_WIDTH]     <= mem_rdata;
                        mem_req                          <= 1'b0;
                        mem_addr                         <= '0;
                        d_done                           <= owner_d_q;
                        i_done                           <= ~owner_d_q;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed bench for cache_refill_arbiter with a small word-addressed memory model.
// Latency is counted in falling-edge samples from the sample where a request is
// raised, i.e. from the grant edge to the rising edge that samples done.
module tb_cache_refill_arbiter;

    logic        Clk;
    logic        Reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic        d_req;
    logic        d_wb;
    logic [31:0] d_wb_addr;
    logic [63:0] d_wb_data;
    logic [31:0] d_addr;
    logic        d_done;
    logic [63:0] rf_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        rdy;
    logic [31:0] mem_rdata;
    logic        busy;

    logic [31:0] mem [0:255];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic        order_q[$];
    int          lat_first;
    int          n_checks;
    int          n_errors;
    int          wr_base;

    cache_refill_arbiter #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .Block_Size (2)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_wb      (d_wb),
        .d_wb_addr (d_wb_addr),
        .d_wb_data (d_wb_data),
        .d_addr    (d_addr),
        .d_done    (d_done),
        .rf_data   (rf_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (rdy),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 Clk = ~Clk;

    assign mem_rdata = mem[mem_addr[9:2]];

    // Record every accepted write beat.
    always @(posedge Clk) begin
        if (!Reset && mem_req && mem_we && rdy) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Raise the requested lines on a falling edge and drop each when its done is seen.
    task automatic serve(input logic want_i, input logic want_d);
        int   n;
        logic pend_i;
        logic pend_d;
        @(negedge Clk);
        i_req     = want_i;
        d_req     = want_d;
        pend_i    = want_i;
        pend_d    = want_d;
        n         = 0;
        lat_first = -1;
        while ((pend_i || pend_d) && n < 40) begin
            @(negedge Clk);
            n++;
            if (pend_d && d_done) begin
                order_q.push_back(1'b1);
                pend_d = 1'b0;
                d_req  = 1'b0;
                if (lat_first < 0) lat_first = n;
            end
            if (pend_i && i_done) begin
                order_q.push_back(1'b0);
                pend_i = 1'b0;
                i_req  = 1'b0;
                if (lat_first < 0) lat_first = n;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        check("serve_timeout", 64'({pend_i, pend_d}), 64'd0);
    endtask

    initial begin
        Clk       = 1'b0;
        Reset     = 1'b1;
        i_req     = 1'b0;
        i_addr    = 32'h0;
        d_req     = 1'b0;
        d_wb      = 1'b0;
        d_wb_addr = 32'h0;
        d_wb_data = 64'h0;
        d_addr    = 32'h0;
        rdy       = 1'b1;
        n_checks  = 0;
        n_errors  = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hF000_0000 | 32'(i);
        mem[32'h100 >> 2] = 32'h11;
        mem[32'h104 >> 2] = 32'h22;
        mem[32'h300 >> 2] = 32'h33;
        mem[32'h304 >> 2] = 32'h44;
        mem[32'h308 >> 2] = 32'h55;
        mem[32'h30C >> 2] = 32'h66;

        // Reset state
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst_busy",   64'(busy), 64'd0);
        check("rst_mreq",   64'(mem_req), 64'd0);
        check("rst_mwe",    64'(mem_we), 64'd0);
        check("rst_maddr",  64'(mem_addr), 64'd0);
        check("rst_mwdata", 64'(mem_wdata), 64'd0);
        check("rst_rf",     rf_data, 64'd0);
        check("rst_done",   64'({i_done, d_done}), 64'd0);
        Reset = 1'b0;

        // D miss without writeback
        d_addr = 32'h104;
        d_wb   = 1'b0;
        wr_base = wr_addr_q.size();
        serve(1'b0, 1'b1);
        check("d_rd_lat",   64'(lat_first), 64'd3);
        check("d_rd_owner", 64'(order_q[order_q.size()-1]), 64'd1);
        check("d_rd_rf",    rf_data, 64'h00000022_00000011);
        check("d_rd_nowr",  64'(wr_addr_q.size() - wr_base), 64'd0);
        @(negedge Clk);
        check("d_rd_rf_hold", rf_data, 64'h00000022_00000011);
        check("d_rd_idle",    64'(busy), 64'd0);

        // D miss with dirty victim; unaligned addresses exercise the offset masking
        d_wb      = 1'b1;
        d_wb_addr = 32'h205;
        d_wb_data = 64'h0000BBBB_0000AAAA;
        d_addr    = 32'h306;
        wr_base   = wr_addr_q.size();
        serve(1'b0, 1'b1);
        check("d_wb_lat",  64'(lat_first), 64'd5);
        check("d_wb_cnt",  64'(wr_addr_q.size() - wr_base), 64'd2);
        if (wr_addr_q.size() - wr_base == 2) begin
            check("d_wb_a0", 64'(wr_addr_q[wr_base]),   64'h200);
            check("d_wb_d0", 64'(wr_data_q[wr_base]),   64'hAAAA);
            check("d_wb_a1", 64'(wr_addr_q[wr_base+1]), 64'h204);
            check("d_wb_d1", 64'(wr_data_q[wr_base+1]), 64'hBBBB);
        end
        check("d_wb_rf", rf_data, 64'h00000044_00000033);
        d_wb = 1'b0;

        // I refill alone
        i_addr = 32'h30C;
        serve(1'b1, 1'b0);
        check("i_lat",   64'(lat_first), 64'd3);
        check("i_owner", 64'(order_q[order_q.size()-1]), 64'd0);
        check("i_rf",    rf_data, 64'h00000066_00000055);

        // Memory stalls for four cycles in RD1; later input changes are ignored
        @(negedge Clk);
        d_addr = 32'h300;
        d_req  = 1'b1;
        @(negedge Clk);
        check("st_rd0_addr", 64'(mem_addr), 64'h300);
        d_addr = 32'h0;
        @(negedge Clk);
        check("st_rd1_addr", 64'(mem_addr), 64'h304);
        check("st_rd1_w0",   64'(rf_data[31:0]), 64'h33);
        rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            check("st_hold_req",  64'(mem_req), 64'd1);
            check("st_hold_addr", 64'(mem_addr), 64'h304);
            check("st_hold_done", 64'(d_done), 64'd0);
        end
        rdy = 1'b1;
        @(negedge Clk);
        check("st_done", 64'(d_done), 64'd1);
        check("st_rf",   rf_data, 64'h00000044_00000033);
        d_req = 1'b0;

        // Simultaneous requests after reset alternate D, I, D, I
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        order_q.delete();
        d_addr = 32'h100;
        i_addr = 32'h300;
        serve(1'b1, 1'b1);
        serve(1'b1, 1'b1);
        check("rr_cnt", 64'(order_q.size()), 64'd4);
        if (order_q.size() == 4) begin
            check("rr_g0", 64'(order_q[0]), 64'd1);
            check("rr_g1", 64'(order_q[1]), 64'd0);
            check("rr_g2", 64'(order_q[2]), 64'd1);
            check("rr_g3", 64'(order_q[3]), 64'd0);
        end

        // Reset during WB1 aborts silently; the reissued request completes
        wr_base = wr_addr_q.size();
        @(negedge Clk);
        d_wb      = 1'b1;
        d_wb_addr = 32'h200;
        d_wb_data = 64'h0000BBBB_0000AAAA;
        d_addr    = 32'h100;
        d_req     = 1'b1;
        @(negedge Clk);
        check("ab_wb0_addr", 64'(mem_addr), 64'h200);
        check("ab_wb0_we",   64'(mem_we), 64'd1);
        @(negedge Clk);
        check("ab_wb1_addr", 64'(mem_addr), 64'h204);
        check("ab_wb1_data", 64'(mem_wdata), 64'hBBBB);
        Reset = 1'b1;
        #1;
        check("ab_busy", 64'(busy), 64'd0);
        check("ab_mreq", 64'({mem_req, mem_we}), 64'd0);
        check("ab_addr", 64'(mem_addr), 64'd0);
        check("ab_wdat", 64'(mem_wdata), 64'd0);
        check("ab_rf",   rf_data, 64'd0);
        d_req = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            check("ab_nodone", 64'({d_done, busy}), 64'd0);
        end
        serve(1'b0, 1'b1);
        check("ab_re_lat", 64'(lat_first), 64'd5);
        check("ab_re_rf",  rf_data, 64'h00000022_00000011);
        check("ab_re_cnt", 64'(wr_addr_q.size() - wr_base), 64'd3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
